// File: rtl/adder_seq_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice adds two WIDTH-bit operands LSB
// nibble first, with the carry chained through a register between cycles.

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_sum;
  logic            nib_cout;
  logic            accept;

  // in_ready is forced low during reset even though state already reads IDLE.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign nib_a = a_q[4*idx +: 4];
  assign nib_b = b_q[4*idx +: 4];

  adder4 u_adder4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Operand capture; later changes on in_a/in_b are invisible to the add.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            carry <= in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          out_sum[4*idx +: 4] <= nib_sum;
          carry               <= nib_cout;
          if (idx == LAST) begin
            out_cout <= nib_cout;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a 16-bit instance checked every cycle against a
// latency/arithmetic model, plus a 4-bit instance for the single-nibble case.

module tb_adder_seq_ctrl;
  localparam int NIB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv, ir, ov, ordy, ci, co;
  logic [15:0] a, b, s;

  logic        iv4, ir4, ov4, ordy4, ci4, co4;
  logic [3:0]  a4, b4, s4;

  adder_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b),
    .in_cin(ci), .out_valid(ov), .out_ready(ordy), .out_sum(s), .out_cout(co)
  );

  adder_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_cin(ci4), .out_valid(ov4), .out_ready(ordy4), .out_sum(s4), .out_cout(co4)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a transaction accepted at an edge yields a+b+cin, visible from
  // NIB edges later until an edge with out_ready; results persist once idle.
  logic        m_busy = 1'b0;
  int          m_k = 0;
  logic [16:0] m_exp = '0;
  logic [16:0] m_hold = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_hold <= '0;
    end else if (m_busy) begin
      if (m_k >= NIB && ordy) begin
        m_busy <= 1'b0;
        m_hold <= m_exp;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (iv) begin
      m_busy <= 1'b1;
      m_k    <= 0;
      m_exp  <= {1'b0, a} + {1'b0, b} + 17'(ci);
    end
  end

  always @(negedge clk) begin : cmp
    logic ev;
    ev = m_busy && (m_k >= NIB);
    chk("out_valid", ov, ev);
    chk("in_ready", ir, !rst && !m_busy);
    if (ev) begin
      chk("out_sum", s, m_exp[15:0]);
      chk("out_cout", co, m_exp[16]);
    end else if (!m_busy) begin
      chk("idle_sum", s, m_hold[15:0]);
      chk("idle_cout", co, m_hold[16]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    int n = 0;
    while (!ir && n < 50) begin tick(); n++; end
    if (!ir) chk("ready_timeout", 0, 1);
    a = aa; b = bb; ci = cc; iv = 1'b1;
    tick();
    iv = 1'b0; a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ov && lat < 50) begin tick(); lat++; end
  endtask

  task automatic txn16(input logic [15:0] aa, input logic [15:0] bb, input logic cc,
                       input logic [15:0] es, input logic ec, input string nm);
    int lat;
    send(aa, bb, cc);
    wait_valid(lat);
    chk({nm, "_latency"}, lat, NIB);
    chk({nm, "_sum"}, s, es);
    chk({nm, "_cout"}, co, ec);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  task automatic txn4(input logic [3:0] aa, input logic [3:0] bb, input logic cc,
                      input logic [4:0] exp, input string nm);
    int lat = 0;
    int n = 0;
    while (!ir4 && n < 20) begin tick(); n++; end
    if (!ir4) chk("ready4_timeout", 0, 1);
    a4 = aa; b4 = bb; ci4 = cc; iv4 = 1'b1;
    tick();
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    while (!ov4 && lat < 20) begin tick(); lat++; end
    chk({nm, "_latency"}, lat, 1);
    chk({nm, "_result"}, {co4, s4}, exp);
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
  endtask

  initial begin
    int lat, c0, c1;
    logic [15:0] s1;
    logic co1, got1;
    logic [15:0] held;

    rst = 1'b1; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; ci = 1'b0;
    iv4 = 1'b0; ordy4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    tick(); tick();
    chk("rst_in_ready", ir, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_sum", {co, s}, 0);
    chk("rst4_in_ready", ir4, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", ir, 1);

    txn16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "t1");
    txn16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "t2");

    // Result must hold while the consumer stalls, ignoring new requests.
    send(16'h0F0F, 16'h1010, 1'b0);
    wait_valid(lat);
    held = s;
    chk("t3_sum", held, 16'h1F1F);
    for (int i = 0; i < 10; i++) begin
      iv = 1'b1; a = 16'($urandom); b = 16'($urandom);
      tick();
      chk("t3_valid", ov, 1);
      chk("t3_hold", s, held);
      chk("t3_ready", ir, 0);
    end
    iv = 1'b0; ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("t3_after_ready", ir, 1);
    chk("t3_after_sum", s, 16'h1F1F);

    send(16'hFFFF, 16'h0001, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t4_valid", ov, 0);
    chk("t4_ready", ir, 0);
    chk("t4_sum", {co, s}, 0);
    tick();
    rst = 1'b0;
    txn16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "t4b");

    // Back-to-back with the consumer always ready.
    ordy = 1'b1;
    a = 16'h8000; b = 16'h8000; ci = 1'b0; iv = 1'b1;
    tick();
    c0 = cyc;
    a = 16'h00FF; b = 16'h0001;
    got1 = 1'b0; s1 = '0; co1 = 1'b0;
    for (int i = 0; i < 30 && !ir; i++) begin
      tick();
      if (ov) begin s1 = s; co1 = co; got1 = 1'b1; end
    end
    tick();
    c1 = cyc;
    iv = 1'b0;
    chk("t5_first_seen", got1, 1);
    chk("t5_first", {co1, s1}, 17'h10000);
    chk("t5_spacing", c1 - c0, NIB + 2);
    wait_valid(lat);
    chk("t5_second", {co, s}, 17'h00100);
    tick();
    ordy = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      iv   = 1'($urandom);
      a    = 16'($urandom);
      b    = 16'($urandom);
      ci   = 1'($urandom);
      ordy = ($urandom % 4) != 0;
      rst  = ($urandom % 300) == 0;
      tick();
    end
    rst = 1'b0; iv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ordy = 1'b0;

    txn4(4'd9, 4'd8, 1'b1, 5'h12, "t6");
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      logic rc;
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      txn4(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 5'(rc), "r4");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
